// File: rtl/ram_port_arbiter_if.sv
// Bundle between the RAM port arbiter and its two requesters plus the single-port RAM.
// The arbiter connects through the slave modport; requesters and the RAM connect through master.
interface ram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  clear_req;
    logic                  init_done;

    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  clear_req,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_q,
        output init_done,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_we, ram_addr, ram_data
    );

    modport master (
        output clear_req,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_q,
        input  init_done,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM, with a zero-fill
// sweep of the whole array after reset and on every clear request.
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic                  init_done_q, init_done_d;

    logic                  gnt0_c, gnt1_c;
    logic                  ram_we_c;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic [DATA_WIDTH-1:0] ram_data_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    // Zero-fill sweep in INIT; single-cycle round-robin grant and RAM mux in RUN.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = '0;
        ram_data_c   = '0;

        case (state_q)
            ST_INIT: begin
                ram_we_c   = 1'b1;
                ram_addr_c = clr_cnt_q;
                clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d   = ST_INIT;
                    clr_cnt_d = '0;
                end else begin
                    // On a tie the requester that did not win last time is served.
                    if (bus.req0_valid && bus.req1_valid) begin
                        gnt0_c = last_grant_q;
                        gnt1_c = ~last_grant_q;
                    end else begin
                        gnt0_c = bus.req0_valid;
                        gnt1_c = bus.req1_valid;
                    end

                    if (gnt0_c) begin
                        last_grant_d = 1'b0;
                        ram_we_c     = bus.req0_we;
                        ram_addr_c   = bus.req0_addr;
                        ram_data_c   = bus.req0_we ? bus.req0_wdata : '0;
                        rsp0_valid_d = ~bus.req0_we;
                    end else if (gnt1_c) begin
                        last_grant_d = 1'b1;
                        ram_we_c     = bus.req1_we;
                        ram_addr_c   = bus.req1_addr;
                        ram_data_c   = bus.req1_we ? bus.req1_wdata : '0;
                        rsp1_valid_d = ~bus.req1_we;
                    end
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase

        init_done_d = (state_d == ST_RUN);
    end

    assign bus.init_done  = init_done_q;
    assign bus.req0_ready = gnt0_c;
    assign bus.req1_ready = gnt1_c;
    assign bus.ram_we     = ram_we_c;
    assign bus.ram_addr   = ram_addr_c;
    assign bus.ram_data   = ram_data_c;

    // RAM output is live in the cycle after a read grant; read data is forced to 0 otherwise.
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_valid_q ? bus.ram_q : '0;
    assign bus.rsp1_rdata = rsp1_valid_q ? bus.ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RAM model, expected-response queues per requester
// and a negedge monitor that pops and compares every response the DUT presents.
module tb_ram_port_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered address, combinational array read.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        ram_addr_q <= bus.ram_addr;
    end
    assign bus.ram_q = mem[ram_addr_q];

    int unsigned cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_tests;
    int   n_fail;
    int   idle_err;
    exp_t q0[$];
    exp_t q1[$];
    logic [DW-1:0] exp_mem [256];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every presented response must match the head of its queue, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp0_valid) begin
            if (q0.size() == 0) begin
                check("rsp0_unexpected", 32'(bus.rsp0_valid), 32'd0);
            end else begin
                e = q0.pop_front();
                check("rsp0_data", 32'(bus.rsp0_rdata), 32'(e.data));
                check("rsp0_cycle", cyc, e.cyc);
            end
        end else if (bus.rsp0_rdata != '0) begin
            idle_err++;
        end
        if (bus.rsp1_valid) begin
            if (q1.size() == 0) begin
                check("rsp1_unexpected", 32'(bus.rsp1_valid), 32'd0);
            end else begin
                e = q1.pop_front();
                check("rsp1_data", 32'(bus.rsp1_rdata), 32'(e.data));
                check("rsp1_cycle", cyc, e.cyc);
            end
        end else if (bus.rsp1_rdata != '0) begin
            idle_err++;
        end
    end

    // One cycle of stimulus with the hand-computed grant pattern (er0/er1).
    task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic clr, input logic er0, input logic er1);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
        bus.clear_req  = clr;
        if (er0) begin
            if (we0) exp_mem[a0] = d0;
            else begin e.data = exp_mem[a0]; e.cyc = cyc + 1; q0.push_back(e); end
        end
        if (er1) begin
            if (we1) exp_mem[a1] = d1;
            else begin e.data = exp_mem[a1]; e.cyc = cyc + 1; q1.push_back(e); end
        end
        if (clr) begin
            for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        end
        @(negedge clk);
        check("req0_ready", 32'(bus.req0_ready), 32'(er0));
        check("req1_ready", 32'(bus.req1_ready), 32'(er1));
        if (er0) begin
            check("ram_addr_g0", 32'(bus.ram_addr), 32'(a0));
            check("ram_we_g0", 32'(bus.ram_we), 32'(we0));
        end else if (er1) begin
            check("ram_addr_g1", 32'(bus.ram_addr), 32'(a1));
            check("ram_we_g1", 32'(bus.ram_we), 32'(we1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int err;
        n_tests = 0; n_fail = 0; idle_err = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = '0;
        end
        rst_n = 1'b0;
        bus.clear_req  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h42; bus.req0_wdata = 8'h00;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h43; bus.req1_wdata = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd1);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_data", 32'(bus.ram_data), 32'd0);
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);

        // Zero-fill sweep: 256 cycles, address tracks cycle, requesters held off.
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (bus.ram_addr != 8'(i) || !bus.ram_we || bus.ram_data != '0 ||
                bus.req0_ready || bus.req1_ready || bus.init_done) err++;
            @(negedge clk);
        end
        check("init_sweep_errs", 32'(err), 32'd0);
        check("init_done_256", 32'(bus.init_done), 32'd1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Every address reads zero after the sweep.
        for (int i = 0; i < 256; i++) drive(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        idle(2);

        // Write then immediate read of the same address.
        drive(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        idle(1);

        // Seed 0x20; then req1 alone for 3 cycles (write, read, read-after-write).
        drive(1, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h22, 0, 0, 1);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 1);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00, 0, 0, 1);

        // Both valid for 4 cycles: last winner was req1, so 0,1,0,1.
        drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 0, 1, 0);
        drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 0, 0, 1);
        drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 0, 1, 0);
        drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 0, 0, 1);
        idle(1);

        // Clear: read in the cycle before still answers; nothing granted for 256 cycles.
        drive(1, 1, 8'h03, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        drive(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        err = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 8'h03, 8'h00, 1, 0, 8'h10, 8'h00, (i == 5), 0, 0);
            if (bus.init_done) err++;
        end
        check("clear_init_done_low", 32'(err), 32'd0);
        drive(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        check("clear_init_done_high", 32'(bus.init_done), 32'd1);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        idle(1);

        // Reset at sweep count 100 restarts the fill from address 0.
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        idle(100);
        @(posedge clk);
        #1;
        check("init_cnt_100", 32'(bus.ram_addr), 32'd100);
        rst_n = 1'b0;
        #1;
        check("rst_mid_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_mid_we", 32'(bus.ram_we), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (255) @(posedge clk);
        @(negedge clk);
        check("rerst_init_done_255", 32'(bus.init_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rerst_init_done_256", 32'(bus.init_done), 32'd1);
        drive(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h64, 8'h00, 0, 0, 1);
        idle(3);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("idle_rdata_nonzero", 32'(idle_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width; RAM depth 2**ADDR_WIDTH.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse: re-run zero-fill of whole RAM.
- init_done  out  1  high when the zero-fill is complete and requests are served.
- req0_valid, req1_valid  in  1  requester N has an access pending.
- req0_ready, req1_ready  out  1  access accepted this cycle.
- req0_we, req1_we  in  1  1 = write, 0 = read.
- req0_addr, req1_addr  in  ADDR_WIDTH  access address.
- req0_wdata, req1_wdata  in  DATA_WIDTH  write data.
- rsp0_valid, rsp1_valid  out  1  read data valid for requester N.
- rsp0_rdata, rsp1_rdata  out  DATA_WIDTH  read data.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM write data.
- ram_q  in  DATA_WIDTH  from RAM; valid one cycle after the address is presented (registered address, combinational array read).

Function
REQ-004 SHALL implement two states: INIT (zero-fill) and RUN (arbitrated access).
REQ-005 In INIT SHALL drive ram_we=1, ram_addr=clr_cnt, ram_data=0 and req0_ready=req1_ready=0, and SHALL increment the ADDR_WIDTH-bit clr_cnt each cycle.
REQ-006 SHALL go INIT->RUN on the edge where clr_cnt equals 2**ADDR_WIDTH-1, with clr_cnt wrapping to 0; INIT lasts exactly 2**ADDR_WIDTH cycles.
REQ-007 init_done SHALL be a register: 1 in RUN, 0 in INIT.
REQ-008 In RUN, clear_req=1 SHALL grant nothing that cycle and go to INIT at the next edge with clr_cnt=0; clear_req SHALL be ignored in INIT.
REQ-009 In RUN without clear_req, exactly one valid requester SHALL be granted (readyN=1) combinationally in the same cycle.
REQ-010 If both requesters are valid, the grant SHALL go to the requester not recorded in last_grant (round-robin); last_grant SHALL update only on a grant.
REQ-011 readyN SHALL never be 1 while reqN_valid=0, and at most one ready SHALL be 1 per cycle.
REQ-012 A granted access SHALL drive ram_addr=reqN_addr and ram_we=reqN_we in the same cycle, and ram_data=reqN_wdata on a write.
REQ-013 With no grant in RUN, the block SHALL drive ram_we=0, ram_addr=0 and ram_data=0.
REQ-014 A granted read at cycle T SHALL set rspN_valid=1 for exactly cycle T+1, with rspN_rdata=ram_q during T+1; rspN_valid SHALL be a register.
REQ-015 rspN_rdata SHALL be 0 whenever rspN_valid=0.
REQ-016 Writes SHALL produce no response.
REQ-017 Back-to-back grants SHALL be sustained at one access per cycle.
REQ-018 A read the cycle after a write to the same address SHALL return the new data.
REQ-019 A read granted in the cycle before clear_req SHALL still deliver its response in the following cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force: state=INIT, clr_cnt=0, last_grant=1 (requester 0 wins the first tie), rsp0_valid=rsp1_valid=0, init_done=0.
REQ-021 While rst_n=0 the block SHALL drive ram_we=1, ram_addr=0, ram_data=0 and both readyN=0.
REQ-022 Reset asserted mid-INIT or mid-RUN SHALL abort in-flight responses and restart the zero-fill from address 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Release rst_n -> init_done=1 exactly 256 cycles later; every address then reads 0x00.
- After init: req0 writes 0x5A to addr 0x10 at T, req0 reads 0x10 at T+1 -> rsp0_valid=1, rsp0_rdata=0x5A at T+2.
- Both requesters hold valid reads for 4 cycles -> grants 0,1,0,1; each rsp arrives one cycle after its grant with the correct data.
- Only req1 valid for 3 cycles -> req1_ready=1 every cycle, req0_ready=0.
- After writing 0xFF to addr 0x03, pulse clear_req -> ready=0 for 256 cycles, init_done=0 then 1; addr 0x03 reads 0x00.
- rst_n asserted at INIT count 100 -> INIT restarts; init_done rises 256 cycles after release.
